// File: rtl/tc_result_unloader.sv
// Buffers whole 4x4 result tiles from the tensor core and streams them out one row per
// beat over valid/ready. Tiles that arrive while the buffer is full are dropped and flagged.
module tc_result_unloader #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [16*DWIDTH-1:0]  C_out,
    input  logic                  out_valid,
    output logic [4*DWIDTH-1:0]   res_data,
    output logic [1:0]            res_row,
    output logic                  res_last,
    output logic                  res_exc,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [15:0]           tile_cnt,
    output logic                  drop_err,
    output logic                  busy
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = 16 * DWIDTH;
    localparam int unsigned RW = 4 * DWIDTH;

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   mem [DEPTH];
    logic [TW-1:0]   head_next;
    logic            fire, pop, full, push, drop;
    logic [RW-1:0]   data_d;
    logic [1:0]      row_d;
    logic            valid_d, last_d, drop_d, busy_d;
    logic [15:0]     tile_cnt_d;

    // Row 0 occupies the top quarter of the packed tile
    function automatic logic [RW-1:0] row_of(input logic [TW-1:0] t, input logic [1:0] r);
        logic [3:0][RW-1:0] rows;
        rows = t;
        return rows[~r];
    endfunction

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wp_q] <= C_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
            res_data  <= '0;
            res_row   <= '0;
            res_last  <= 1'b0;
            res_valid <= 1'b0;
            tile_cnt  <= '0;
            drop_err  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            cnt_q     <= cnt_d;
            res_data  <= data_d;
            res_row   <= row_d;
            res_last  <= last_d;
            res_valid <= valid_d;
            tile_cnt  <= tile_cnt_d;
            drop_err  <= drop_d;
            busy      <= busy_d;
        end
    end

    always_comb begin
        fire       = res_valid & res_ready;
        pop        = fire & (res_row == 2'd3);
        full       = (cnt_q == CW'(DEPTH));
        push       = out_valid & (~full | pop);
        drop       = out_valid & full & ~pop;
        cnt_d      = cnt_q + CW'(push) - CW'(pop);
        wp_d       = push ? wp_q + PW'(1) : wp_q;
        rp_d       = pop ? rp_q + PW'(1) : rp_q;
        // The next head may be the tile being written this very cycle
        head_next  = (push && (wp_q == rp_d)) ? C_out : mem[rp_d];
        state_d    = state_q;
        row_d      = res_row;
        data_d     = res_data;
        valid_d    = res_valid;
        last_d     = res_last;
        tile_cnt_d = tile_cnt + 16'(pop);
        drop_d     = drop_err | drop;
        busy_d     = (cnt_d != '0);
        case (state_q)
            IDLE: begin
                if (cnt_q != '0) begin
                    state_d = SEND;
                    row_d   = 2'd0;
                    data_d  = row_of(mem[rp_q], 2'd0);
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                end
            end
            SEND: begin
                if (pop) begin
                    row_d  = 2'd0;
                    last_d = 1'b0;
                    if (cnt_d != '0) begin
                        data_d = row_of(head_next, 2'd0);
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end else if (fire) begin
                    row_d  = res_row + 2'd1;
                    data_d = row_of(mem[rp_q], res_row + 2'd1);
                    last_d = (res_row == 2'd2);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Inf/NaN detect on the presented row
    always_comb begin
        res_exc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            res_exc = res_exc | (&res_data[i*DWIDTH + DWIDTH-2 -: 5]);
        end
    end

endmodule

// File: doc/tc_result_unloader.md
# tc_result_unloader

Drains completed 4x4 FP16 result tiles from `tensor_core_top` and streams them row by row to a downstream consumer over a valid/ready handshake. The tensor core emits `C_out` with a single-cycle `out_valid` and has no backpressure, so this block buffers up to `DEPTH` whole tiles, serializes each into four row beats, and flags any tile lost to a full buffer. It sits directly on the tensor core output, as the reading end of the `C_out`/`out_valid` interface.

## Interface
- `DWIDTH`, 16, element width (FP16).
- `DEPTH`, 2, tile buffer depth in whole tiles; power of two, at least 2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `C_out` input 16*DWIDTH: packed tile, element [r][c] at bits [(15-(4r+c))*DWIDTH +: DWIDTH], so [0][0] is in the MSBs.
- `out_valid` input 1: tile present on `C_out` this cycle. Single-cycle strobe; no ready signal back.
- `res_data` output 4*DWIDTH: one row; element [r][0] in the MSBs.
- `res_row` output 2: row index of the current beat.
- `res_last` output 1: high on row 3.
- `res_exc` output 1: high when any element of the row has exponent == 5'b11111 (Inf or NaN).
- `res_valid` output 1: beat valid.
- `res_ready` input 1: consumer accepts the beat.
- `tile_cnt` output 16: count of tiles fully drained; wraps at 2^16.
- `drop_err` output 1: sticky; set when a tile is lost to a full buffer.
- `busy` output 1: buffer not empty.

## Operation
- **Buffer:** a `DEPTH`-entry tile FIFO with write pointer `wp`, read pointer `rp`, and occupancy `cnt` of width log2(DEPTH)+1.
- **Push:** when `out_valid` is high and the FIFO is not full (or is freed this cycle, see below), write `C_out` at `wp`, then increment `wp` modulo `DEPTH`.
- **Drop:** when `out_valid` is high and the FIFO is full with no pop this cycle, discard the tile and set `drop_err`. Nothing else changes. `drop_err` clears only on `rst`.
- **Drain state machine**, states IDLE and SEND:
  - IDLE to SEND when `cnt` is nonzero (registered). `row` is set to 0.
  - SEND presents the row `row` of the tile at `rp` with `res_valid` = 1.
  - A beat fires when `res_valid` and `res_ready` are both high. On a fire with `row` < 3, increment `row`.
  - On a fire with `row` == 3 (pop): increment `rp`, decrement `cnt`, and increment `tile_cnt`. Then go to SEND with `row` = 0 if tiles remain, otherwise go to IDLE.
- **Simultaneous push and pop:** `cnt` is unchanged.
  - A push into a full FIFO in the same cycle as a pop is accepted, not dropped.
- **Hold rule:** while `res_valid` is high and `res_ready` is low, `res_data`, `res_row`, `res_last` and `res_exc` hold stable. `res_valid` never deasserts without a fire.
- **`res_exc`:** for each of the four elements, compute the AND of bits [DWIDTH-2 -: 5]; `res_exc` is the OR of those four results, taken combinationally from the presented row.
- **Passthrough:** no arithmetic is done on the data. Bits pass through unmodified.

## Timing
- **Reset values:** `res_valid` = 0, `res_row` = 0, `res_last` = 0, `res_exc` = 0, `res_data` = 0, `tile_cnt` = 0, `drop_err` = 0, `busy` = 0. Pointers and `cnt` = 0, state IDLE.
- **Latency:**
  - A tile pushed at edge N gives row 0 with `res_valid` at cycle N+1 when the FIFO was empty and IDLE.
  - `res_valid` is registered; no combinational path from `out_valid` to `res_valid`.
- **Throughput:** with `res_ready` held high, one row per cycle and 4 cycles per tile. There are no bubbles between back-to-back buffered tiles.
- **`busy`:** `busy` = (`cnt` != 0), registered alongside `cnt`.
- **Reset mid-operation:** `rst` high at any edge flushes all tiles and drops any in-flight beat. The next cycle shows the reset values. An `out_valid` in the same cycle as `rst` is ignored.
- **Wrap-around:** `wp` and `rp` wrap modulo `DEPTH`. `tile_cnt` wraps from 16'hFFFF to 0.

## Test plan
- **Single tile:** tile with element [r][c] = 4r+c, `res_ready` = 1.
  - Required: beats at cycles N+1..N+4 with `res_data` = {0,1,2,3}, {4,5,6,7}, {8,9,10,11}, {12,13,14,15}.
  - `res_last` only on the 4th beat; `tile_cnt` = 1; `busy` = 0 after.
- **Backpressure:** toggle `res_ready` 1,0,0,1,… during a tile.
  - Required: the row is held while stalled; exactly 4 fires in order 0..3; no duplicated or skipped row.
- **Overflow:** `res_ready` = 0; three `out_valid` strobes with tiles A, B, C.
  - Required: `drop_err` = 1 after C.
  - Releasing `res_ready` then drains exactly A then B; `tile_cnt` = 2.
- **Full plus pop:** FIFO full, `res_ready` = 1, and a new tile arrives on the cycle row 3 of the head fires.
  - Required: the new tile is accepted, `drop_err` stays 0, and all tiles drain in order.
- **Exception flag:** a tile whose row 2 contains 16'h7C00 (+Inf) and whose row 0 contains 16'h7BFF.
  - Required: `res_exc` = 1 only on row 2.
- **Reset mid-drain:** assert `rst` after the 2nd beat of a tile.
  - Required: the next cycle has `res_valid` = 0, `tile_cnt` = 0, `busy` = 0, `drop_err` = 0.
  - A subsequent tile streams from row 0 normally.
